// File: rtl/temp_alarm_ctrl.sv
// temp_alarm_ctrl: over-temperature alarm sequencer with hysteresis,
// N-sample confirmation, event pulses and a blinking alarm LED.
module temp_alarm_ctrl #(
  parameter int unsigned TEMP_W = 16,
  parameter logic [TEMP_W-1:0] HI_DEFAULT = TEMP_W'(16'h0EA6),
  parameter logic [TEMP_W-1:0] LO_DEFAULT = TEMP_W'(16'h0E80),
  parameter int unsigned CONFIRM_N = 4,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [TEMP_W-1:0] cfg_data,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              alarm,
  output logic              alarm_set,
  output logic              alarm_clr,
  output logic              led
);

  localparam int unsigned BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0] CONF = 8'(CONFIRM_N);

  typedef enum logic [1:0] {
    NORMAL,
    RISE_CHK,
    ALARM,
    FALL_CHK
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [7:0]        count;
  logic [7:0]        count_n;
  logic [7:0]        count_inc;
  logic [TEMP_W-1:0] hi_thr;
  logic [TEMP_W-1:0] lo_thr;
  logic [BW-1:0]     blink_cnt;
  logic              above;
  logic              below;
  logic              wr_ok;
  logic              alarm_n;
  logic              set_ev;
  logic              clr_ev;

  assign above = temp_valid && (temp_in > hi_thr);
  assign below = temp_valid && (temp_in < lo_thr);
  assign count_inc = count + 8'd1;

  // candidate pair is (new hi, old lo) or (old hi, new lo)
  assign wr_ok = cfg_sel ? (cfg_data <= hi_thr)
                         : (lo_thr <= cfg_data);

  // next-state and confirm-count logic
  always_comb begin
    state_n = state;
    count_n = count;
    unique case (state)
      NORMAL: begin
        if (above) begin
          if (CONF == 8'd1) begin
            state_n = ALARM;
            count_n = 8'd0;
          end else begin
            state_n = RISE_CHK;
            count_n = 8'd1;
          end
        end
      end
      RISE_CHK: begin
        if (temp_valid) begin
          if (!above) begin
            state_n = NORMAL;
            count_n = 8'd0;
          end else if (count_inc == CONF) begin
            state_n = ALARM;
            count_n = 8'd0;
          end else begin
            count_n = count_inc;
          end
        end
      end
      ALARM: begin
        if (below) begin
          if (CONF == 8'd1) begin
            state_n = NORMAL;
            count_n = 8'd0;
          end else begin
            state_n = FALL_CHK;
            count_n = 8'd1;
          end
        end
      end
      FALL_CHK: begin
        if (temp_valid) begin
          if (!below) begin
            state_n = ALARM;
            count_n = 8'd0;
          end else if (count_inc == CONF) begin
            state_n = NORMAL;
            count_n = 8'd0;
          end else begin
            count_n = count_inc;
          end
        end
      end
      default: begin
        state_n = NORMAL;
        count_n = 8'd0;
      end
    endcase
  end

  assign alarm_n = (state_n == ALARM) || (state_n == FALL_CHK);
  assign set_ev  = !alarm && (state_n == ALARM);
  assign clr_ev  = (state == FALL_CHK) && (state_n == NORMAL);

  // state register and registered alarm level/pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORMAL;
      count     <= 8'd0;
      alarm     <= 1'b0;
      alarm_set <= 1'b0;
      alarm_clr <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      alarm     <= alarm_n;
      alarm_set <= set_ev;
      alarm_clr <= clr_ev;
    end
  end

  // LED blink: restarts on alarm entry, free-runs while alarm holds
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= 1'b0;
      blink_cnt <= '0;
    end else if (set_ev) begin
      led       <= 1'b1;
      blink_cnt <= '0;
    end else if (!alarm_n) begin
      led       <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      led       <= ~led;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // threshold registers with ordered-pair write check
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_thr  <= HI_DEFAULT;
      lo_thr  <= LO_DEFAULT;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_we && wr_ok;
      cfg_err <= cfg_we && !wr_ok;
      if (cfg_we && wr_ok) begin
        if (cfg_sel) lo_thr <= cfg_data;
        else         hi_thr <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// tb_temp_alarm_ctrl: directed bench for temp_alarm_ctrl with a
// streak/phase reference model checked every cycle.
module tb_temp_alarm_ctrl;

  localparam int N  = 3;
  localparam int BD = 4;
  localparam logic [15:0] HI = 16'h0EA6;
  localparam logic [15:0] LO = 16'h0E80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] temp_in = '0;
  logic        temp_valid = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ack;
  logic        cfg_err;
  logic        alarm;
  logic        alarm_set;
  logic        alarm_clr;
  logic        led;

  int n_cmp = 0;
  int n_bad = 0;

  temp_alarm_ctrl #(
    .TEMP_W(16),
    .HI_DEFAULT(HI),
    .LO_DEFAULT(LO),
    .CONFIRM_N(N),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .temp_in(temp_in),
    .temp_valid(temp_valid),
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
    .cfg_ack(cfg_ack),
    .cfg_err(cfg_err),
    .alarm(alarm),
    .alarm_set(alarm_set),
    .alarm_clr(alarm_clr),
    .led(led)
  );

  always #5 clk = ~clk;

  // reference model: alarm flag, run length of confirming samples,
  // and cycles elapsed since the alarm was raised
  bit          m_alarm;
  bit          m_set;
  bit          m_clr;
  bit          m_ack;
  bit          m_err;
  bit          m_live = 1'b0;
  int          m_streak;
  int          m_phase;
  logic [15:0] m_hi;
  logic [15:0] m_lo;

  always @(posedge clk) begin
    bit above;
    bit below;
    bit prev;
    m_live = 1'b1;
    if (rst) begin
      m_alarm = 0; m_set = 0; m_clr = 0;
      m_ack = 0; m_err = 0;
      m_streak = 0; m_phase = 0;
      m_hi = HI; m_lo = LO;
    end else begin
      above = temp_valid && (temp_in > m_hi);
      below = temp_valid && (temp_in < m_lo);
      m_set = 0; m_clr = 0;
      m_ack = cfg_we && (cfg_sel ? (cfg_data <= m_hi)
                                 : (m_lo <= cfg_data));
      m_err = cfg_we && !m_ack;
      if (m_ack) begin
        if (cfg_sel) m_lo = cfg_data;
        else         m_hi = cfg_data;
      end
      prev = m_alarm;
      if (temp_valid) begin
        if ((!prev && above) || (prev && below)) begin
          m_streak++;
          if (m_streak == N) begin
            m_alarm = !prev;
            m_set = !prev;
            m_clr = prev;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
      if (prev && m_alarm) m_phase++;
      else m_phase = 0;
    end
  end

  function automatic bit m_led();
    return m_alarm && (((m_phase / BD) % 2) == 0);
  endfunction

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  // compare against the model at the negedge, then drive inputs
  task automatic step(input bit r, input bit v,
                      input logic [15:0] t, input bit we,
                      input bit sel, input logic [15:0] d);
    logic [5:0] got;
    logic [5:0] exp;
    @(negedge clk);
    if (m_live) begin
      got = {alarm, alarm_set, alarm_clr, led, cfg_ack, cfg_err};
      exp = {m_alarm, m_set, m_clr, m_led(), m_ack, m_err};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model: got %b want %b at %0t",
                 got, exp, $time);
      end
    end
    rst = r; temp_valid = v; temp_in = t;
    cfg_we = we; cfg_sel = sel; cfg_data = d;
  endtask

  task automatic samp(input logic [15:0] t);
    step(0, 1, t, 0, 0, '0);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0);
  endtask

  task automatic cfg(input bit sel, input logic [15:0] d);
    step(0, 0, '0, 1, sel, d);
  endtask

  task automatic do_rst();
    step(1, 0, '0, 0, 0, '0);
  endtask

  initial begin
    do_rst();
    do_rst();
    idle();
    chk("reset_alarm", alarm, 1'b0);
    chk("reset_led", led, 1'b0);

    // 1: three samples above hi raise the alarm
    repeat (3) samp(16'h0EA7);
    idle();
    chk("t1_alarm", alarm, 1'b1);
    chk("t1_set", alarm_set, 1'b1);
    chk("t1_led", led, 1'b1);
    idle();
    chk("t1_set_once", alarm_set, 1'b0);
    repeat (3) samp(16'h0E7F);
    idle();
    chk("t1_clr", alarm_clr, 1'b1);
    chk("t1_clr_alarm", alarm, 1'b0);

    // 2: equal-to-threshold sample breaks the run
    samp(16'h0EA7); samp(16'h0EA7);
    samp(16'h0EA6); samp(16'h0EA7);
    idle();
    chk("t2_no_alarm", alarm, 1'b0);
    samp(16'h0EA7);
    idle();
    chk("t2_count2", alarm, 1'b0);
    samp(16'h0EA7);
    idle();
    chk("t2_alarm", alarm, 1'b1);

    // 3: hysteresis band holds, then below lo clears
    repeat (5) samp(16'h0E90);
    idle();
    chk("t3_band", alarm, 1'b1);
    repeat (3) samp(16'h0E7F);
    idle();
    chk("t3_clr", alarm_clr, 1'b1);
    chk("t3_alarm", alarm, 1'b0);
    chk("t3_led", led, 1'b0);

    // 4: blink pattern, then a FALL_CHK excursion
    repeat (3) samp(16'h0EA7);
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("t4_blink", led, ((i / 4) % 2) == 0);
    end
    samp(16'h0E7F);
    idle();
    chk("t4_fall", alarm, 1'b1);
    samp(16'h0EA0);
    idle();
    chk("t4_back", alarm, 1'b1);
    repeat (6) idle();
    repeat (3) samp(16'h0E7F);
    idle();
    chk("t4_clr", alarm, 1'b0);

    // 5: threshold writes
    cfg(1, 16'h0F00);
    idle();
    chk("t5_err", cfg_err, 1'b1);
    chk("t5_no_ack", cfg_ack, 1'b0);
    cfg(1, 16'h0EA6);
    idle();
    chk("t5_lo_eq_hi", cfg_ack, 1'b1);
    cfg(1, 16'h0E80);
    cfg(0, 16'h0F10);
    idle();
    chk("t5_ack", cfg_ack, 1'b1);
    repeat (3) samp(16'h0F00);
    idle();
    chk("t5_no_alarm", alarm, 1'b0);
    step(0, 1, 16'h0EA7, 1, 0, 16'h0EA6);
    samp(16'h0EA7); samp(16'h0EA7);
    idle();
    chk("t5_old_hi", alarm, 1'b0);
    samp(16'h0EA7);
    idle();
    chk("t5_new_hi", alarm, 1'b1);
    repeat (3) samp(16'h0E7F);
    idle();

    // 6: reset in RISE_CHK and in ALARM
    cfg(0, 16'h0F10);
    samp(16'h0F11); samp(16'h0F11);
    do_rst();
    idle();
    chk("t6_rise_alarm", alarm, 1'b0);
    chk("t6_rise_led", led, 1'b0);
    samp(16'h0EA7); samp(16'h0EA7);
    idle();
    chk("t6_fresh", alarm, 1'b0);
    samp(16'h0EA7);
    idle();
    chk("t6_alarm", alarm, 1'b1);
    do_rst();
    idle();
    chk("t6_alm_alarm", alarm, 1'b0);
    chk("t6_alm_led", led, 1'b0);
    samp(16'h0EA7); samp(16'h0EA7);
    idle();
    chk("t6_fresh2", alarm, 1'b0);
    samp(16'h0EA7);
    idle();
    chk("t6_alarm2", alarm, 1'b1);
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
